uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx serializer (8n1, LSB first) between NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity: once a requester is granted, it keeps the UART until its byte flagged last has been sent, so packets never interleave on the line.
- Sits between the fizzbuzz message generators and uart_tx, and sequences uart_tx's start/busy handshake.

Parameters:
- NUM_REQ, 2, number of requesters (1..8); index width RW = max(1, $clog2(NUM_REQ)).
- GAP_CLKS, 0, idle clocks inserted after each packet before re-arbitration (0 = none).
- MAX_HOLD_CLKS, 0, clocks a granted requester may stall mid-packet before its grant is revoked (0 = never revoke).
- ACCEPT_CLKS, 4, clocks allowed for i_tx_busy to rise after o_tx_start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  requester k has a byte available.
- i_req_data  in  8*NUM_REQ  byte of requester k at bits [8k+7:8k].
- i_req_last  in  NUM_REQ  byte of requester k is the last of its packet.
- o_req_ready  out  NUM_REQ  one-hot; byte of requester k consumed this cycle.
- o_grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- o_tx_start  out  1  one-cycle start pulse to uart_tx.
- o_tx_data  out  8  byte to uart_tx; valid when o_tx_start = 1, otherwise 0.
- i_tx_busy  in  1  uart_tx is serializing.
- o_err  out  1  sticky flag: busy failed to rise within ACCEPT_CLKS.

Behaviour:
- Reset: synchronous, active-high. All outputs 0. State IDLE. Last-granted pointer = NUM_REQ-1, so requester 0 wins first. Counters 0. Reset mid-packet abandons the packet; the uart_tx frame in progress is not affected.
- Outputs are decoded combinationally from registered state/grant. o_tx_start and o_req_ready[g] are asserted together for exactly 1 cycle per byte.
- IDLE:
  - o_grant = 0.
  - If any i_req_valid is set, pick the first set index scanning (ptr+1) mod NUM_REQ upward with wrap. Register it as g and go to SEND.
  - Cost: 1 cycle of arbitration latency.
- SEND:
  - o_tx_start = 1, o_tx_data = i_req_data[g], o_req_ready[g] = 1.
  - Latch i_req_last[g] into last_q, load the accept counter, go to WAIT_ACC.
  - i_req_valid[g] is guaranteed high on entry.
- WAIT_ACC:
  - If i_tx_busy = 1, go to WAIT_DONE.
  - Otherwise decrement the counter. On expiry set o_err and go to WAIT_DONE anyway, so the arbiter never deadlocks.
- WAIT_DONE: when i_tx_busy = 0:
  - If last_q = 1: ptr <= g; go to GAP (load GAP_CLKS), or straight to IDLE if GAP_CLKS = 0.
  - Else if i_req_valid[g] = 1: go to SEND (back-to-back bytes, no re-arbitration).
  - Else: go to HOLD and load the hold counter.
- HOLD:
  - Grant is retained; other requesters are blocked.
  - i_req_valid[g] = 1: go to SEND.
  - If MAX_HOLD_CLKS > 0 and the counter expires: ptr <= g, go to IDLE. The grant is dropped and the remaining bytes of the packet are sent later as a new packet.
  - Valid and expiry in the same cycle: valid wins.
- GAP: counts GAP_CLKS cycles with o_grant still held, then goes to IDLE.
- Byte period: a byte issued in SEND is followed by at least 3 cycles overhead plus the uart_tx frame before the next SEND.
- Requester contract: valid/data/last stay stable until ready. The arbiter never consumes without starting a frame.
- NUM_REQ = 1: arbitration degenerates to a pass-through with identical sequencing.
- Counters are sized $clog2(max+1) and saturate at 0.

Decomposition:
- Shared package uart_pkg:
  - typedef arb_state_t {IDLE, SEND, WAIT_ACC, WAIT_DONE, HOLD, GAP}.
  - Constant UART_DATA_BITS = 8.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, ptr.
  - Outputs: any_req, pick index.
  - Reusable by future arbiters in the codebase.

Test Plan:
- Single packet: NUM_REQ=2, req0 sends {0x46,0x69(last)}, uart_tx model with busy 10 cycles → exactly 2 o_tx_start pulses, data 0x46 then 0x69, o_grant=01 throughout, then 00.
- Round robin: req0 and req1 both valid with 1-byte packets 0xAA/0x55, held continuously → start data order 0xAA,0x55,0xAA,0x55; never two consecutive grants to the same requester.
- No interleave: req0 3-byte packet, req1 raises valid after the first byte → all 3 req0 bytes go out before any req1 byte.
- Mid-packet stall with MAX_HOLD_CLKS=5: req0 drops valid after byte 1, req1 valid → grant released after 5 HOLD cycles and req1 byte sent next. With MAX_HOLD_CLKS=0, req1 waits indefinitely.
- Accept timeout: uart_tx model never raises busy → o_err=1 after 4 cycles, FSM proceeds, next byte still issued; o_err stays 1 until rst.
- Reset mid-packet: assert rst during WAIT_DONE of byte 2 of req1 → next cycle all outputs 0; first grant after reset goes to req0 if both are valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: byte width, arbiter state
// encoding and a small elaboration-time helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACC,
        WAIT_DONE,
        HOLD,
        GAP
    } arb_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requesting index
// found scanning upward from i_ptr+1 with wrap-around.
module rr_pick #(
    parameter int N  = 2,
    parameter int RW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [RW-1:0] i_ptr,
    output logic          o_any,
    output logic [RW-1:0] o_pick
);

    logic [RW-1:0] w_idx;

    assign o_any = |i_req;

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        w_idx  = '0;
        o_pick = '0;
        // Scan from the farthest offset down so the nearest requester wins.
        for (int off = N; off >= 1; off--) begin
            w_idx = RW'((int'(i_ptr) + off) % N);
            if (i_req[w_idx]) begin
                o_pick = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one 8n1 uart_tx between
// NUM_REQ byte-stream requesters and sequencing its start/busy handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int GAP_CLKS      = 0,
    parameter int MAX_HOLD_CLKS = 0,
    parameter int ACCEPT_CLKS   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [UART_DATA_BITS*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]                i_req_last,
    output logic [NUM_REQ-1:0]                o_req_ready,
    output logic [NUM_REQ-1:0]                o_grant,
    output logic                              o_tx_start,
    output logic [UART_DATA_BITS-1:0]         o_tx_data,
    input  logic                              i_tx_busy,
    output logic                              o_err
);

    localparam int RW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = max_int(max_int(GAP_CLKS, MAX_HOLD_CLKS), ACCEPT_CLKS);
    localparam int CNT_W   = max_int(1, $clog2(CNT_MAX + 1));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_t       r_state, w_state_nxt;
    logic [RW-1:0]    r_gnt, w_gnt_nxt;
    logic [RW-1:0]    r_ptr, w_ptr_nxt;
    logic [RW-1:0]    w_pick;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_dec;
    logic             r_last, w_last_nxt;
    logic             r_err, w_err_nxt;
    logic             w_any, w_gnt_valid, w_gnt_last;

    rr_pick #(
        .N  (NUM_REQ),
        .RW (RW)
    ) u_rr_pick (
        .i_req  (i_req_valid),
        .i_ptr  (r_ptr),
        .o_any  (w_any),
        .o_pick (w_pick)
    );

    assign w_gnt_valid = i_req_valid[r_gnt];
    assign w_gnt_last  = i_req_last[r_gnt];
    // One counter serves accept, hold and gap timing; only one is live per state.
    assign w_cnt_dec   = (r_cnt != '0) ? r_cnt - CNT_ONE : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_err_nxt   = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_last_nxt  = w_gnt_last;
                w_cnt_nxt   = CNT_W'(ACCEPT_CLKS);
                w_state_nxt = WAIT_ACC;
            end
            WAIT_ACC: begin
                if (i_tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_cnt <= CNT_ONE) begin
                    // Never deadlock on a silent serializer: flag it and move on.
                    w_err_nxt   = 1'b1;
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    if (r_last) begin
                        w_ptr_nxt = r_gnt;
                        if (GAP_CLKS > 0) begin
                            w_cnt_nxt   = CNT_W'(GAP_CLKS);
                            w_state_nxt = GAP;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (w_gnt_valid) begin
                        w_state_nxt = SEND;
                    end else begin
                        w_cnt_nxt   = CNT_W'(MAX_HOLD_CLKS);
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_gnt_valid) begin
                    w_state_nxt = SEND;
                end else if (MAX_HOLD_CLKS > 0 && r_cnt <= CNT_ONE) begin
                    w_ptr_nxt   = r_gnt;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            GAP: begin
                if (r_cnt <= CNT_ONE) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= RW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        o_grant     = '0;
        o_req_ready = '0;
        o_tx_start  = 1'b0;
        o_tx_data   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_gnt == RW'(k)) begin
                o_grant[k] = (r_state != IDLE);
                if (r_state == SEND) begin
                    o_tx_start     = 1'b1;
                    o_req_ready[k] = 1'b1;
                    o_tx_data      = i_req_data[k*UART_DATA_BITS +: UART_DATA_BITS];
                end
            end
        end
    end

    assign o_err = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// packet traffic scored against a packet-level round-robin reference model.
module tb_uart_tx_arbiter;

    localparam int NR       = 2;
    localparam int GAP      = 2;
    localparam int MAX_HOLD = 5;
    localparam int ACCEPT   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   i_req_valid, i_req_last, o_req_ready, o_grant;
    logic [8*NR-1:0] i_req_data;
    logic            o_tx_start, i_tx_busy, o_err;
    logic [7:0]      o_tx_data;

    uart_tx_arbiter #(
        .NUM_REQ       (NR),
        .GAP_CLKS      (GAP),
        .MAX_HOLD_CLKS (MAX_HOLD),
        .ACCEPT_CLKS   (ACCEPT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .i_tx_busy   (i_tx_busy),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Requester side: each queue entry is {last, data}.
    logic [8:0]    rq [NR][$];
    logic [NR-1:0] stall = '0;
    logic [NR-1:0] stall_arm = '0;
    logic [7:0]    seen [$];
    logic [NR-1:0] ready_seen = '0;
    logic          start_seen = 1'b0;

    // Reference model: last packet owner and owner of the packet in flight.
    int m_ptr   = NR - 1;
    int m_owner = -1;

    // Serializer model.
    bit uart_on = 1'b1;
    int u_len_lo = 10, u_len_hi = 10, u_dly_hi = 0;
    int u_wait = 0, u_left = 0;

    int hold_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seen_at(input int i);
        if (i < seen.size()) return seen[i];
        return 8'hxx;
    endfunction

    function automatic int pending();
        int p = 0;
        for (int k = 0; k < NR; k++) if (!stall[k]) p += rq[k].size();
        return p;
    endfunction

    // Packet-level rule: an open packet keeps its owner; otherwise the first
    // requester holding bytes after the last owner, with wrap, goes next.
    function automatic int model_pick();
        if (m_owner >= 0) return (rq[m_owner].size() > 0) ? m_owner : -1;
        for (int i = 1; i <= NR; i++) begin
            int k = (m_ptr + i) % NR;
            if (rq[k].size() > 0 && !stall[k]) return k;
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < NR; k++) begin
            if (rq[k].size() > 0 && !stall[k]) begin
                i_req_valid[k]      = 1'b1;
                i_req_data[8*k +: 8] = rq[k][0][7:0];
                i_req_last[k]       = rq[k][0][8];
            end else begin
                i_req_valid[k]      = 1'b0;
                i_req_data[8*k +: 8] = 8'h00;
                i_req_last[k]       = 1'b0;
            end
        end
    endtask

    task automatic push(input int k, input logic [7:0] data, input logic last);
        rq[k].push_back({last, data});
    endtask

    task automatic sample();
        int         exp_k;
        logic [8:0] head;
        ready_seen = o_req_ready;
        start_seen = o_tx_start;
        if (o_grant == NR'(1) && !i_tx_busy && !o_tx_start) hold_cnt++;
        if (o_tx_start) begin
            exp_k = model_pick();
            if (exp_k < 0) begin
                check("start_without_request", 32'(o_tx_start), 32'd0);
            end else begin
                head = rq[exp_k][0];
                check("ready_onehot", 32'(o_req_ready), 32'd1 << exp_k);
                check("grant_onehot", 32'(o_grant), 32'd1 << exp_k);
                check("tx_data", 32'(o_tx_data), 32'(head[7:0]));
                // A stalled packet is abandoned after the hold limit, so its
                // remaining bytes compete again as a fresh packet.
                if (head[8] || stall_arm[exp_k]) begin
                    m_ptr   = exp_k;
                    m_owner = -1;
                end else begin
                    m_owner = exp_k;
                end
            end
            seen.push_back(o_tx_data);
        end else begin
            check("idle_outputs", 32'({o_req_ready, o_tx_data}), 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (ready_seen[k] && rq[k].size() > 0) begin
                void'(rq[k].pop_front());
                if (stall_arm[k]) begin
                    stall[k]     = 1'b1;
                    stall_arm[k] = 1'b0;
                end
            end
        end
        if (start_seen && uart_on) begin
            u_wait = int'($urandom_range(u_dly_hi, 0));
            u_left = int'($urandom_range(u_len_hi, u_len_lo));
        end
        if (u_wait > 0) begin
            u_wait--;
            i_tx_busy = 1'b0;
        end else if (u_left > 0) begin
            u_left--;
            i_tx_busy = 1'b1;
        end else begin
            i_tx_busy = 1'b0;
        end
        drive_inputs();
        @(negedge clk);
        sample();
    endtask

    task automatic clear_requesters();
        for (int k = 0; k < NR; k++) rq[k].delete();
        stall     = '0;
        stall_arm = '0;
        m_ptr     = NR - 1;
        m_owner   = -1;
        seen.delete();
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_requesters();
        step();
        step();
        rst = 1'b0;
        hold_cnt = 0;
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (pending() > 0 && c < budget) begin
            step();
            c++;
        end
        check("drain_budget", 32'(pending()), 32'd0);
        repeat (40) step();
    endtask

    task automatic wait_starts(input int n, input int budget);
        int c = 0;
        while (seen.size() < n && c < budget) begin
            step();
            c++;
        end
        check("wait_starts", 32'(seen.size()), 32'(n));
    endtask

    initial begin
        int bad;
        int c;
        int total;
        int npk;
        int len;

        rst         = 1'b1;
        i_tx_busy   = 1'b0;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;

        // Reset state.
        do_reset();
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_start", 32'(o_tx_start), 32'd0);
        check("rst_data", 32'(o_tx_data), 32'd0);
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);

        // Single two-byte packet from requester 0.
        push(0, 8'h46, 1'b0);
        push(0, 8'h69, 1'b1);
        drive_inputs();
        wait_starts(1, 50);
        bad = 0;
        c   = 0;
        while (seen.size() < 2 && c < 200) begin
            step();
            c++;
            if (o_grant !== NR'(1)) bad++;
        end
        check("single_grant_held", 32'(bad), 32'd0);
        drain(400);
        check("single_count", 32'(seen.size()), 32'd2);
        check("single_b0", 32'(seen_at(0)), 32'h46);
        check("single_b1", 32'(seen_at(1)), 32'h69);
        check("single_grant_released", 32'(o_grant), 32'd0);

        // Round robin between two always-ready requesters.
        do_reset();
        u_len_lo = 4;
        u_len_hi = 8;
        push(0, 8'hAA, 1'b1);
        push(0, 8'hAA, 1'b1);
        push(1, 8'h55, 1'b1);
        push(1, 8'h55, 1'b1);
        drive_inputs();
        drain(800);
        check("rr_count", 32'(seen.size()), 32'd4);
        check("rr_0", 32'(seen_at(0)), 32'hAA);
        check("rr_1", 32'(seen_at(1)), 32'h55);
        check("rr_2", 32'(seen_at(2)), 32'hAA);
        check("rr_3", 32'(seen_at(3)), 32'h55);

        // No interleave: requester 1 arrives after requester 0 has started.
        do_reset();
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        drive_inputs();
        wait_starts(1, 50);
        push(1, 8'hB0, 1'b1);
        drive_inputs();
        drain(800);
        check("nointl_count", 32'(seen.size()), 32'd4);
        check("nointl_0", 32'(seen_at(0)), 32'hA0);
        check("nointl_1", 32'(seen_at(1)), 32'hA1);
        check("nointl_2", 32'(seen_at(2)), 32'hA2);
        check("nointl_3", 32'(seen_at(3)), 32'hB0);

        // Mid-packet stall: requester 0 goes quiet after its first byte.
        do_reset();
        u_len_lo = 6;
        u_len_hi = 6;
        push(0, 8'hD1, 1'b0);
        push(0, 8'hD2, 1'b1);
        stall_arm[0] = 1'b1;
        push(1, 8'h77, 1'b1);
        drive_inputs();
        hold_cnt = 0;
        wait_starts(2, 200);
        // One WAIT_DONE cycle sees the idle line, then MAX_HOLD cycles of HOLD.
        check("hold_cycles", 32'(hold_cnt), 32'(1 + MAX_HOLD));
        check("hold_next_byte", 32'(seen_at(1)), 32'h77);
        stall[0] = 1'b0;
        drive_inputs();
        drain(400);
        check("hold_count", 32'(seen.size()), 32'd3);
        check("hold_resume", 32'(seen_at(2)), 32'hD2);

        // Accept timeout: the serializer never raises busy.
        do_reset();
        uart_on = 1'b0;
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b1);
        drive_inputs();
        wait_starts(1, 50);
        check("err_at_start", 32'(o_err), 32'd0);
        repeat (ACCEPT) step();
        check("err_before_expiry", 32'(o_err), 32'd0);
        step();
        check("err_after_expiry", 32'(o_err), 32'd1);
        drain(400);
        check("timeout_count", 32'(seen.size()), 32'd2);
        check("timeout_b1", 32'(seen_at(1)), 32'h22);
        check("err_sticky", 32'(o_err), 32'd1);
        uart_on = 1'b1;
        do_reset();
        check("err_cleared", 32'(o_err), 32'd0);

        // Reset while requester 1's second byte is on the line.
        u_len_lo = 10;
        u_len_hi = 10;
        push(1, 8'hB1, 1'b0);
        push(1, 8'hB2, 1'b1);
        drive_inputs();
        wait_starts(2, 200);
        repeat (3) step();
        check("midrst_grant_before", 32'(o_grant), 32'd2);
        rst = 1'b1;
        clear_requesters();
        step();
        check("midrst_grant", 32'(o_grant), 32'd0);
        check("midrst_start", 32'(o_tx_start), 32'd0);
        check("midrst_data", 32'(o_tx_data), 32'd0);
        check("midrst_ready", 32'(o_req_ready), 32'd0);
        check("midrst_err", 32'(o_err), 32'd0);
        rst = 1'b0;
        push(0, 8'hC0, 1'b1);
        push(1, 8'hC1, 1'b1);
        drive_inputs();
        drain(400);
        check("midrst_count", 32'(seen.size()), 32'd2);
        check("midrst_first", 32'(seen_at(0)), 32'hC0);
        check("midrst_second", 32'(seen_at(1)), 32'hC1);

        // Randomized packet traffic against the reference model.
        do_reset();
        u_len_lo = 2;
        u_len_hi = 12;
        u_dly_hi = 2;
        total    = 0;
        for (int round = 0; round < 15; round++) begin
            for (int k = 0; k < NR; k++) begin
                npk = int'($urandom_range(3, 0));
                for (int p = 0; p < npk; p++) begin
                    len = int'($urandom_range(3, 1));
                    for (int b = 0; b < len; b++) begin
                        push(k, 8'($urandom), (b == len - 1));
                        total++;
                    end
                end
            end
            drive_inputs();
            drain(3000);
        end
        check("rand_bytes", 32'(seen.size()), 32'(total));
        check("rand_err", 32'(o_err), 32'd0);
        check("rand_idle_grant", 32'(o_grant), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
